// File: rtl/apb_wait_slave_if.sv
// APB bus bundle between a requester and apb_wait_slave.
// Latency: none (wires only). Backpressure: carried by pready.
interface apb_wait_slave_if;
    logic       psel;
    logic       pena;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwr_data;
    logic [7:0] pdata;
    logic       pready;
    logic       pslverr;

    modport master (
        output psel, pena, pwrite, paddr, pwr_data,
        input  pdata, pready, pslverr
    );

    modport slave (
        input  psel, pena, pwrite, paddr, pwr_data,
        output pdata, pready, pslverr
    );
endinterface

// File: rtl/apb_wait_slave.sv
// APB register-file slave with WAIT_CYCLES wait states; APB_SLV_PSLVERR_EN adds out-of-range pslverr.
// Latency: pready rises WAIT_CYCLES cycles after the first pena cycle (0 = zero-wait completion).
// Backpressure: holds pready low while counting; dropping psel mid-transfer aborts it with no write.
module apb_wait_slave #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            pclk,
    input  logic            preset,
    apb_wait_slave_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [7:0] addr_q,  addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       write_q, write_d;
    logic [7:0] regs_q [DEPTH];

    logic          in_range;
    logic          done;
    logic [AW-1:0] idx;

    assign idx      = addr_q[AW-1:0];
    assign in_range = ({1'b0, addr_q} < 9'(DEPTH));

    // The first pena cycle is already spent in SETUP, so a zero count completes there.
    assign done = (state_q != IDLE) && (cnt_q == 4'd0) && bus.psel && bus.pena;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        unique case (state_q)
            IDLE: begin
                if (bus.psel && !bus.pena) begin
                    state_d = SETUP;
                    cnt_d   = 4'(WAIT_CYCLES);
                    addr_d  = bus.paddr;
                    wdata_d = bus.pwr_data;
                    write_d = bus.pwrite;
                end
            end
            SETUP, ACCESS: begin
                if (!bus.psel || done) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ACCESS;
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (done && write_q && in_range) begin
            regs_q[idx] <= wdata_q;
        end
    end

    assign bus.pready = done;
    assign bus.pdata  = (done && !write_q && in_range) ? regs_q[idx] : 8'h00;

`ifdef APB_SLV_PSLVERR_EN
    assign bus.pslverr = done && !in_range;
`else
    assign bus.pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_wait_slave.sv
// Bench for apb_wait_slave: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance, table rows plus corner sequences.
module tb_apb_wait_slave;
    localparam int DEPTH = 16;
`ifdef APB_SLV_PSLVERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic pclk = 1'b0;
    logic preset;
    always #5 pclk = ~pclk;

    apb_wait_slave_if bw2();
    apb_wait_slave_if bw0();

    apb_wait_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (.pclk(pclk), .preset(preset), .bus(bw2));
    apb_wait_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (.pclk(pclk), .preset(preset), .bus(bw0));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         waits;
        logic [7:0] rd;
        logic       err;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int         d;      // wait cycles, also selects the instance
        bit         w;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] rd;
        bit         oor;
        bit         b2b;
    } vec_t;
    vec_t tbl[14];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(int d, logic s, logic e, logic w, logic [7:0] a, logic [7:0] wd);
        if (d == 0) begin
            bw0.psel = s; bw0.pena = e; bw0.pwrite = w; bw0.paddr = a; bw0.pwr_data = wd;
        end else begin
            bw2.psel = s; bw2.pena = e; bw2.pwrite = w; bw2.paddr = a; bw2.pwr_data = wd;
        end
    endtask

    task automatic sample(int d, output logic rdy, output logic err, output logic [7:0] rd);
        if (d == 0) begin
            rdy = bw0.pready; err = bw0.pslverr; rd = bw0.pdata;
        end else begin
            rdy = bw2.pready; err = bw2.pslverr; rd = bw2.pdata;
        end
    endtask

    // Entered just after a rising edge; returns just after the edge that ends the pready cycle.
    task automatic xfer(string lbl, int d, bit w, logic [7:0] a, logic [7:0] wd, logic [7:0] rd, bit oor);
        exp_t       e;
        int         n;
        logic       rdy, err;
        logic [7:0] pd;
        exp_q.push_back('{waits: d, rd: (w ? 8'h00 : rd), err: (oor & ERR_ON)});
        drive(d, 1'b1, 1'b0, w, a, wd);
        @(posedge pclk); #1;
        drive(d, 1'b1, 1'b1, w, ~a, ~wd);   // must not disturb the captured transfer
        n   = 0;
        rdy = 1'b0;
        err = 1'b0;
        pd  = 8'h00;
        while (!rdy && n <= 40) begin
            @(negedge pclk);
            sample(d, rdy, err, pd);
            if (!rdy) begin
                n++;
                @(posedge pclk); #1;
            end
        end
        e = exp_q.pop_front();
        check({lbl, " waits"}, 32'(n), 32'(e.waits));
        check({lbl, " pdata"}, 32'(pd), 32'(e.rd));
        check({lbl, " pslverr"}, 32'(err), 32'(e.err));
        @(posedge pclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic       rdy, err;
        logic [7:0] pd;
        int         n;

        tbl[0]  = '{2, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{2, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, 1'b0};
        tbl[2]  = '{2, 1'b1, 8'h0F, 8'h3C, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{2, 1'b0, 8'h0F, 8'h00, 8'h3C, 1'b0, 1'b0};
        tbl[4]  = '{2, 1'b1, 8'h20, 8'hFF, 8'h00, 1'b1, 1'b0};
        tbl[5]  = '{2, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{2, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[7]  = '{2, 1'b1, 8'h10, 8'h77, 8'h00, 1'b1, 1'b0};
        tbl[8]  = '{2, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[9]  = '{2, 1'b0, 8'h0F, 8'h00, 8'h3C, 1'b0, 1'b0};
        tbl[10] = '{0, 1'b1, 8'h00, 8'h11, 8'h00, 1'b0, 1'b1};
        tbl[11] = '{0, 1'b1, 8'h01, 8'h22, 8'h00, 1'b0, 1'b1};
        tbl[12] = '{0, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0, 1'b1};
        tbl[13] = '{0, 1'b0, 8'h01, 8'h00, 8'h22, 1'b0, 1'b0};

        preset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        for (int d = 0; d <= 2; d += 2) begin
            sample(d, rdy, err, pd);
            check($sformatf("reset%0d pready", d), 32'(rdy), 32'd0);
            check($sformatf("reset%0d pdata", d), 32'(pd), 32'd0);
            check($sformatf("reset%0d pslverr", d), 32'(err), 32'd0);
        end
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;

        foreach (tbl[i]) begin
            xfer($sformatf("row%0d", i), tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].oor);
            if (!tbl[i].b2b) begin
                drive(tbl[i].d, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
                @(posedge pclk); #1;
            end
        end

        // pena without a setup phase must not start a transfer
        drive(2, 1'b1, 1'b1, 1'b1, 8'h05, 8'h99);
        for (int c = 0; c < 4; c++) begin
            @(negedge pclk);
            sample(2, rdy, err, pd);
            check($sformatf("nosetup c%0d pready", c), 32'(rdy), 32'd0);
            @(posedge pclk); #1;
        end
        drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge pclk); #1;

        // psel dropped in the first wait cycle aborts the write
        drive(2, 1'b1, 1'b0, 1'b1, 8'h05, 8'h5A);
        @(posedge pclk); #1;
        drive(2, 1'b1, 1'b1, 1'b1, 8'h05, 8'h5A);
        @(negedge pclk);
        sample(2, rdy, err, pd);
        check("abort wait pready", 32'(rdy), 32'd0);
        @(posedge pclk); #1;
        drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            sample(2, rdy, err, pd);
            check($sformatf("abort idle c%0d pready", c), 32'(rdy), 32'd0);
        end
        @(posedge pclk); #1;
        xfer("abort readback", 2, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge pclk); #1;

        // reset in the completing access cycle of a write to 0x07
        drive(2, 1'b1, 1'b0, 1'b1, 8'h07, 8'h77);
        @(posedge pclk); #1;
        drive(2, 1'b1, 1'b1, 1'b1, 8'h07, 8'h77);
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n <= 10) begin
            @(negedge pclk);
            sample(2, rdy, err, pd);
            if (!rdy) begin
                n++;
                @(posedge pclk); #1;
            end
        end
        check("rst pre pready", 32'(rdy), 32'd1);
        #1 preset = 1'b1;
        #1;
        sample(2, rdy, err, pd);
        check("rst async pready", 32'(rdy), 32'd0);
        check("rst async pdata", 32'(pd), 32'd0);
        check("rst async pslverr", 32'(err), 32'd0);
        drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge pclk); #1;
        preset = 1'b0;
        xfer("rst read07", 2, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge pclk); #1;
        xfer("rst read03", 2, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        xfer("rst w0 read00", 0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge pclk); #1;

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
